// File: rtl/costas_pkg.sv
// Shared definitions for the Costas carrier-loop supervisor: state encoding and width defaults.
package costas_pkg;

    localparam int unsigned ERR_W_DEF  = 13;
    localparam int unsigned COEF_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REWORK = 2'd1,
        ST_ACQ    = 2'd2,
        ST_TRK    = 2'd3
    } costas_state_e;

    // A zero count threshold is treated as one window.
    function automatic logic [7:0] at_least_one(input logic [7:0] n);
        return (n == '0) ? 8'd1 : n;
    endfunction

endpackage

// File: rtl/costas_err_window.sv
// Phase-error magnitude accumulator over a 2**WIN_LOG2-strobe window; pulses window_done with the full sum.
module costas_err_window
    import costas_pkg::*;
#(
    parameter int unsigned ERR_W    = ERR_W_DEF,
    parameter int unsigned WIN_LOG2 = 6,
    localparam int unsigned SUM_W   = ERR_W + WIN_LOG2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    count_en,
    input  logic                    rdy,
    input  logic signed [ERR_W-1:0] err,
    output logic                    window_done,
    output logic [SUM_W-1:0]        window_sum
);

    logic [ERR_W-1:0]    mag;
    logic [SUM_W-1:0]    acc;
    logic [SUM_W-1:0]    sum_full;
    logic [WIN_LOG2-1:0] cnt;

    // Most-negative input saturates to the largest positive magnitude.
    always_comb begin
        mag = err;
        if (err[ERR_W-1]) begin
            if (err == {1'b1, {(ERR_W-1){1'b0}}})
                mag = {1'b0, {(ERR_W-1){1'b1}}};
            else
                mag = ~err + 1'b1;
        end
    end

    assign sum_full = acc + SUM_W'(mag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            window_done <= 1'b0;
            window_sum  <= '0;
        end else if (clear) begin
            acc         <= '0;
            cnt         <= '0;
            window_done <= 1'b0;
        end else begin
            window_done <= 1'b0;
            if (count_en && rdy) begin
                if (cnt == '1) begin
                    window_sum  <= sum_full;
                    window_done <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= sum_full;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/costas_lock_supervisor.sv
// Costas loop supervisor: restart sequencing, acquisition/tracking coefficient selection and lock detection.
module costas_lock_supervisor
    import costas_pkg::*;
#(
    parameter int unsigned CORDIC_OUTPUT_DATA_WIDTH  = ERR_W_DEF,
    parameter int unsigned FLL_PLL_COEFFICIENT_WIDTH = COEF_W_DEF,
    parameter int unsigned WINDOW_LEN_LOG2           = 6,
    parameter int unsigned REWORK_CYCLES             = 4,
    localparam int unsigned ERR_W  = CORDIC_OUTPUT_DATA_WIDTH,
    localparam int unsigned COEF_W = FLL_PLL_COEFFICIENT_WIDTH,
    localparam int unsigned SUM_W  = ERR_W + WINDOW_LEN_LOG2
) (
    input  logic                    iw_Clk_p_g,
    input  logic                    iw_Rst_n_g,
    input  logic                    iw_Enable,
    input  logic                    iw_Force_ReWork_h,
    input  logic                    iw_Carr_Error_Rdy_h,
    input  logic signed [ERR_W-1:0] iw_Carr_Phase_Error,
    input  logic [COEF_W-1:0]       iw_Acq_C1,
    input  logic [COEF_W-1:0]       iw_Acq_C2,
    input  logic [COEF_W-1:0]       iw_Acq_C3,
    input  logic [COEF_W-1:0]       iw_Trk_C1,
    input  logic [COEF_W-1:0]       iw_Trk_C2,
    input  logic [COEF_W-1:0]       iw_Trk_C3,
    input  logic [SUM_W-1:0]        iw_Lock_Thresh,
    input  logic [SUM_W-1:0]        iw_Unlock_Thresh,
    input  logic [7:0]              iw_Lock_Count,
    input  logic [7:0]              iw_Unlock_Count,
    input  logic [15:0]             iw_Acq_Timeout,
    output logic [COEF_W-1:0]       ow_PLL_C1,
    output logic [COEF_W-1:0]       ow_PLL_C2,
    output logic [COEF_W-1:0]       ow_PLL_C3,
    output logic                    ow_Loop_Filter_ReWork_h,
    output logic                    ow_Locked,
    output logic [1:0]              ow_State,
    output logic [SUM_W-1:0]        ow_Window_Err_Sum,
    output logic [7:0]              ow_Relock_Cnt
);

    localparam int unsigned RW_W = $clog2(REWORK_CYCLES + 1);

    costas_state_e     state, state_n;
    logic [RW_W-1:0]   rw_cnt, rw_cnt_n;
    logic [7:0]        good, good_n, bad, bad_n, relock, relock_n;
    logic [15:0]       tmo, tmo_n;
    logic [COEF_W-1:0] c1, c2, c3, c1_n, c2_n, c3_n;
    logic [SUM_W-1:0]  sum_q, sum_n;
    logic              rework_q, locked_q;
    logic              enter_rework, relock_inc;
    logic [8:0]        good_w, bad_w;
    logic [16:0]       tmo_w;
    logic              win_done, count_en;
    logic [SUM_W-1:0]  win_sum;

    assign count_en = (state == ST_ACQ) || (state == ST_TRK);

    costas_err_window #(
        .ERR_W    (ERR_W),
        .WIN_LOG2 (WINDOW_LEN_LOG2)
    ) u_err_window (
        .clk         (iw_Clk_p_g),
        .rst_n       (iw_Rst_n_g),
        .clear       (!count_en),
        .count_en    (count_en),
        .rdy         (iw_Carr_Error_Rdy_h),
        .err         (iw_Carr_Phase_Error),
        .window_done (win_done),
        .window_sum  (win_sum)
    );

    always_comb begin
        state_n      = state;
        rw_cnt_n     = rw_cnt;
        good_n       = good;
        bad_n        = bad;
        tmo_n        = tmo;
        c1_n         = c1;
        c2_n         = c2;
        c3_n         = c3;
        relock_n     = relock;
        sum_n        = sum_q;
        enter_rework = 1'b0;
        relock_inc   = 1'b0;
        good_w       = (win_sum < iw_Lock_Thresh)   ? ({1'b0, good} + 9'd1) : '0;
        bad_w        = (win_sum > iw_Unlock_Thresh) ? ({1'b0, bad} + 9'd1)  : '0;
        tmo_w        = {1'b0, tmo} + 17'd1;

        if (win_done)
            sum_n = win_sum;

        if (!iw_Enable) begin
            state_n = ST_IDLE;
        end else if (iw_Force_ReWork_h && state != ST_IDLE) begin
            enter_rework = 1'b1;
        end else begin
            case (state)
                ST_IDLE: enter_rework = 1'b1;
                ST_REWORK: begin
                    if (rw_cnt == RW_W'(REWORK_CYCLES - 1))
                        state_n = ST_ACQ;
                    else
                        rw_cnt_n = rw_cnt + 1'b1;
                end
                ST_ACQ: begin
                    if (win_done) begin
                        good_n = good_w[7:0];
                        tmo_n  = tmo_w[15:0];
                        // Lock is checked first so it wins over a coincident timeout.
                        if (good_w >= {1'b0, at_least_one(iw_Lock_Count)}) begin
                            state_n = ST_TRK;
                            c1_n    = iw_Trk_C1;
                            c2_n    = iw_Trk_C2;
                            c3_n    = iw_Trk_C3;
                            bad_n   = '0;
                        end else if (iw_Acq_Timeout != '0 && tmo_w >= {1'b0, iw_Acq_Timeout}) begin
                            enter_rework = 1'b1;
                            relock_inc   = 1'b1;
                        end
                    end
                end
                ST_TRK: begin
                    if (win_done) begin
                        bad_n = bad_w[7:0];
                        if (bad_w >= {1'b0, at_least_one(iw_Unlock_Count)}) begin
                            enter_rework = 1'b1;
                            relock_inc   = 1'b1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        if (enter_rework) begin
            state_n  = ST_REWORK;
            rw_cnt_n = '0;
            c1_n     = iw_Acq_C1;
            c2_n     = iw_Acq_C2;
            c3_n     = iw_Acq_C3;
            good_n   = '0;
            bad_n    = '0;
            tmo_n    = '0;
        end

        if (relock_inc && relock != 8'hFF)
            relock_n = relock + 8'd1;
    end

    always_ff @(posedge iw_Clk_p_g or negedge iw_Rst_n_g) begin
        if (!iw_Rst_n_g) begin
            state    <= ST_IDLE;
            rw_cnt   <= '0;
            good     <= '0;
            bad      <= '0;
            tmo      <= '0;
            c1       <= '0;
            c2       <= '0;
            c3       <= '0;
            relock   <= '0;
            sum_q    <= '0;
            rework_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_n;
            rw_cnt   <= rw_cnt_n;
            good     <= good_n;
            bad      <= bad_n;
            tmo      <= tmo_n;
            c1       <= c1_n;
            c2       <= c2_n;
            c3       <= c3_n;
            relock   <= relock_n;
            sum_q    <= sum_n;
            rework_q <= (state_n == ST_REWORK);
            locked_q <= (state_n == ST_TRK);
        end
    end

    assign ow_PLL_C1               = c1;
    assign ow_PLL_C2               = c2;
    assign ow_PLL_C3               = c3;
    assign ow_Loop_Filter_ReWork_h = rework_q;
    assign ow_Locked               = locked_q;
    assign ow_State                = state;
    assign ow_Window_Err_Sum       = sum_q;
    assign ow_Relock_Cnt           = relock;

endmodule

// File: tb/tb_costas_lock_supervisor.sv
// Directed self-checking bench for costas_lock_supervisor with a window-sum scoreboard.
module tb_costas_lock_supervisor;

    localparam int unsigned ERR_W  = 13;
    localparam int unsigned COEF_W = 32;
    localparam int unsigned SUM_W  = 19;

    localparam logic [31:0] ACQ1 = 32'h1111_0001, ACQ2 = 32'h1111_0002, ACQ3 = 32'h1111_0003;
    localparam logic [31:0] TRK1 = 32'h2222_0001, TRK2 = 32'h2222_0002, TRK3 = 32'h2222_0003;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic                    force_rw = 1'b0;
    logic                    rdy = 1'b0;
    logic signed [ERR_W-1:0] err = '0;
    logic [COEF_W-1:0]       acq_c1 = ACQ1, acq_c2 = ACQ2, acq_c3 = ACQ3;
    logic [COEF_W-1:0]       trk_c1 = TRK1, trk_c2 = TRK2, trk_c3 = TRK3;
    logic [SUM_W-1:0]        lock_thr = 19'd1000;
    logic [SUM_W-1:0]        unlock_thr = 19'd5000;
    logic [7:0]              lock_cnt = 8'd2;
    logic [7:0]              unlock_cnt = 8'd3;
    logic [15:0]             acq_tmo = 16'd0;
    logic [COEF_W-1:0]       pll_c1, pll_c2, pll_c3;
    logic                    rework;
    logic                    locked;
    logic [1:0]              state;
    logic [SUM_W-1:0]        win_sum;
    logic [7:0]              relock_cnt;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int          sb[$];
    int          n;

    costas_lock_supervisor #(
        .CORDIC_OUTPUT_DATA_WIDTH  (ERR_W),
        .FLL_PLL_COEFFICIENT_WIDTH (COEF_W),
        .WINDOW_LEN_LOG2           (6),
        .REWORK_CYCLES             (4)
    ) dut (
        .iw_Clk_p_g              (clk),
        .iw_Rst_n_g              (rst_n),
        .iw_Enable               (enable),
        .iw_Force_ReWork_h       (force_rw),
        .iw_Carr_Error_Rdy_h     (rdy),
        .iw_Carr_Phase_Error     (err),
        .iw_Acq_C1               (acq_c1),
        .iw_Acq_C2               (acq_c2),
        .iw_Acq_C3               (acq_c3),
        .iw_Trk_C1               (trk_c1),
        .iw_Trk_C2               (trk_c2),
        .iw_Trk_C3               (trk_c3),
        .iw_Lock_Thresh          (lock_thr),
        .iw_Unlock_Thresh        (unlock_thr),
        .iw_Lock_Count           (lock_cnt),
        .iw_Unlock_Count         (unlock_cnt),
        .iw_Acq_Timeout          (acq_tmo),
        .ow_PLL_C1               (pll_c1),
        .ow_PLL_C2               (pll_c2),
        .ow_PLL_C3               (pll_c3),
        .ow_Loop_Filter_ReWork_h (rework),
        .ow_Locked               (locked),
        .ow_State                (state),
        .ow_Window_Err_Sum       (win_sum),
        .ow_Relock_Cnt           (relock_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_model(input int e);
        if (e <= -4096) return 4095;
        return (e < 0) ? -e : e;
    endfunction

    task automatic do_reset();
        enable   = 1'b0;
        force_rw = 1'b0;
        rdy      = 1'b0;
        rst_n    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic measure_rework(output int len);
        len = 0;
        while (rework && len < 20) begin
            len++;
            tick();
        end
    endtask

    // One full window of constant error; expected sum is queued and compared after the decision edge.
    task automatic send_window(input int e, input string tag);
        int exp_sum;
        err = ERR_W'(e);
        for (int i = 0; i < 64; i++) begin
            rdy = 1'b1;
            tick();
        end
        rdy = 1'b0;
        sb.push_back(64 * mag_model(e));
        tick();
        exp_sum = sb.pop_front();
        chk(tag, 32'(win_sum), exp_sum);
    endtask

    task automatic chk_coefs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                             input logic [31:0] e3);
        chk({tag, "_c1"}, pll_c1, e1);
        chk({tag, "_c2"}, pll_c2, e2);
        chk({tag, "_c3"}, pll_c3, e3);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_state", 32'(state), 0);
        chk("rst_rework", 32'(rework), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_sum", 32'(win_sum), 0);
        chk("rst_relock", 32'(relock_cnt), 0);
        chk_coefs("rst", 0, 0, 0);

        // Acquire and lock on a small error
        enable = 1'b1;
        tick();
        chk("t1_state_rework", 32'(state), 1);
        measure_rework(n);
        chk("t1_rework_len", n, 4);
        chk("t1_state_acq", 32'(state), 2);
        chk_coefs("t1_acq", ACQ1, ACQ2, ACQ3);
        send_window(5, "t1_win1_sum");
        chk("t1_win1_state", 32'(state), 2);
        send_window(5, "t1_win2_sum");
        chk("t1_locked", 32'(locked), 1);
        chk("t1_state_trk", 32'(state), 3);
        chk_coefs("t1_trk", TRK1, TRK2, TRK3);

        // Loss of lock after three bad windows
        send_window(100, "t2_win1_sum");
        chk("t2_win1_state", 32'(state), 3);
        send_window(100, "t2_win2_sum");
        chk("t2_win2_state", 32'(state), 3);
        send_window(100, "t2_win3_sum");
        chk("t2_state_rework", 32'(state), 1);
        chk("t2_unlocked", 32'(locked), 0);
        chk("t2_relock", 32'(relock_cnt), 1);
        chk_coefs("t2_acq", ACQ1, ACQ2, ACQ3);
        measure_rework(n);
        chk("t2_rework_len", n, 4);

        // Relock, then software restart and disable priority
        send_window(5, "t5_win1_sum");
        send_window(5, "t5_win2_sum");
        chk("t5_state_trk", 32'(state), 3);
        force_rw = 1'b1;
        tick();
        force_rw = 1'b0;
        chk("t5_force_state", 32'(state), 1);
        chk("t5_force_locked", 32'(locked), 0);
        chk("t5_force_relock", 32'(relock_cnt), 1);
        chk_coefs("t5_force", ACQ1, ACQ2, ACQ3);
        enable   = 1'b0;
        force_rw = 1'b1;
        tick();
        force_rw = 1'b0;
        chk("t5_dis_state", 32'(state), 0);
        chk("t5_dis_rework", 32'(rework), 0);
        chk("t5_dis_locked", 32'(locked), 0);
        chk("t5_dis_c1_hold", pll_c1, ACQ1);

        // Acquisition timeout and relock-counter saturation
        do_reset();
        lock_cnt = 8'd2;
        acq_tmo  = 16'd5;
        enable   = 1'b1;
        tick();
        measure_rework(n);
        chk("t3_rework_len", n, 4);
        for (int w = 1; w <= 4; w++) begin
            send_window(-4096, "t3_win_sum");
            chk("t3_win_state", 32'(state), 2);
        end
        send_window(-4096, "t3_win5_sum");
        chk("t3_timeout_state", 32'(state), 1);
        chk("t3_timeout_relock", 32'(relock_cnt), 1);
        acq_tmo = 16'd1;
        for (int r = 0; r < 260; r++) begin
            measure_rework(n);
            send_window(-4096, "t3_sat_sum");
        end
        chk("t3_relock_sat", 32'(relock_cnt), 255);
        chk("t3_sat_state", 32'(state), 1);

        // Good/bad alternation with Lock_Count=3
        do_reset();
        acq_tmo  = 16'd0;
        lock_cnt = 8'd3;
        enable   = 1'b1;
        tick();
        measure_rework(n);
        send_window(5, "t4_g1");
        send_window(5, "t4_g2");
        send_window(100, "t4_b3");
        chk("t4_state_after_bad", 32'(state), 2);
        send_window(5, "t4_g4");
        send_window(5, "t4_g5");
        chk("t4_state_after_5", 32'(state), 2);
        send_window(5, "t4_g6");
        chk("t4_state_after_6", 32'(state), 3);
        chk("t4_locked", 32'(locked), 1);

        // Async reset mid-acquisition, then a fresh window
        do_reset();
        enable = 1'b1;
        tick();
        measure_rework(n);
        err = 13'sd100;
        for (int i = 0; i < 30; i++) begin
            rdy = 1'b1;
            tick();
        end
        rdy   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", 32'(state), 0);
        chk("t6_rst_rework", 32'(rework), 0);
        chk("t6_rst_sum", 32'(win_sum), 0);
        chk("t6_rst_c1", pll_c1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        measure_rework(n);
        chk("t6_rework_len", n, 4);
        send_window(5, "t6_fresh_sum");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
